// File: rtl/sev_seg_capture.sv
// Captures a multiplexed seven-segment display back into per-digit hex registers.
// Inputs are synchronized, qualified by a stability counter, and evaluated once per stable vector.
module sev_seg_capture #(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  a,
  input  logic                  b,
  input  logic                  c,
  input  logic                  d,
  input  logic                  e,
  input  logic                  f,
  input  logic                  g,
  input  logic                  dot,
  input  logic [DIGITS-1:0]     an,
  output logic [4*DIGITS-1:0]   digits,
  output logic [DIGITS-1:0]     dots,
  output logic [DIGITS-1:0]     valid,
  output logic                  upd,
  output logic [3:0]            upd_idx,
  output logic                  err
);

  localparam int VW = DIGITS + 8;
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);

  typedef enum logic [1:0] {TRACK, EVAL, HOLD} state_t;

  state_t          state_q, state_d;
  logic [VW-1:0]   sync1, s_cur, s_prev;
  logic [CW-1:0]   cnt, cnt_next;
  logic            changed;

  logic [DIGITS-1:0]   ev_an;
  logic [6:0]          ev_seg;
  logic                ev_dot;
  logic                an_zero, an_multi;
  logic [4:0]          dec;
  logic [3:0]          idx;
  logic [4*DIGITS-1:0] digits_wr;

  // Returns {hit, value}; hit is 0 for any pattern outside the hex table.
  function automatic logic [4:0] hex_decode(input logic [6:0] seg);
    case (seg)
      7'b1111110: hex_decode = 5'h10;
      7'b0110000: hex_decode = 5'h11;
      7'b1101101: hex_decode = 5'h12;
      7'b1111001: hex_decode = 5'h13;
      7'b0110011: hex_decode = 5'h14;
      7'b1011011: hex_decode = 5'h15;
      7'b1011111: hex_decode = 5'h16;
      7'b1110000: hex_decode = 5'h17;
      7'b1111111: hex_decode = 5'h18;
      7'b1111011: hex_decode = 5'h19;
      7'b1110111: hex_decode = 5'h1A;
      7'b0011111: hex_decode = 5'h1B;
      7'b1001110: hex_decode = 5'h1C;
      7'b0111101: hex_decode = 5'h1D;
      7'b1001111: hex_decode = 5'h1E;
      7'b1000111: hex_decode = 5'h1F;
      default:    hex_decode = 5'h00;
    endcase
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1   <= '0;
      s_cur   <= '0;
      s_prev  <= '0;
      cnt     <= '0;
      state_q <= TRACK;
    end else begin
      sync1   <= {an, a, b, c, d, e, f, g, dot};
      s_cur   <= sync1;
      s_prev  <= s_cur;
      cnt     <= cnt_next;
      state_q <= state_d;
    end
  end

  assign changed = (s_cur != s_prev);

  always_comb begin
    cnt_next = cnt;
    if (changed)              cnt_next = CW'(1);
    else if (cnt != CNT_MAX)  cnt_next = cnt + CW'(1);
  end

  // A change arriving during EVAL goes straight back to TRACK so the new vector is not lost.
  always_comb begin
    state_d = state_q;
    case (state_q)
      TRACK:   if (cnt_next == CNT_MAX) state_d = EVAL;
      EVAL:    state_d = changed ? TRACK : HOLD;
      HOLD:    if (changed) state_d = TRACK;
      default: state_d = TRACK;
    endcase
  end

  // s_prev still holds the vector that was counted stable while in EVAL.
  assign ev_an    = s_prev[VW-1:8];
  assign ev_seg   = s_prev[7:1];
  assign ev_dot   = s_prev[0];
  assign an_zero  = (ev_an == '0);
  assign an_multi = ((ev_an & (ev_an - DIGITS'(1))) != '0);
  assign dec      = hex_decode(ev_seg);

  always_comb begin
    idx       = '0;
    digits_wr = digits;
    for (int i = 0; i < DIGITS; i++) begin
      if (ev_an[i]) begin
        idx                  = 4'(i);
        digits_wr[4*i +: 4]  = dec[3:0];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      digits  <= '0;
      dots    <= '0;
      valid   <= '0;
      upd     <= 1'b0;
      upd_idx <= '0;
      err     <= 1'b0;
    end else begin
      upd <= 1'b0;
      err <= 1'b0;
      if (state_q == EVAL && !an_zero) begin
        if (an_multi) begin
          err <= 1'b1;
        end else if (ev_seg == 7'b0) begin
          valid   <= valid & ~ev_an;
          dots    <= (dots & ~ev_an) | (ev_an & {DIGITS{ev_dot}});
          upd     <= 1'b1;
          upd_idx <= idx;
        end else if (dec[4]) begin
          digits  <= digits_wr;
          valid   <= valid | ev_an;
          dots    <= (dots & ~ev_an) | (ev_an & {DIGITS{ev_dot}});
          upd     <= 1'b1;
          upd_idx <= idx;
        end else begin
          err   <= 1'b1;
          valid <= valid & ~ev_an;
        end
      end
    end
  end

endmodule

// File: tb/tb_sev_seg_capture.sv
// Directed bench for sev_seg_capture: pulses are matched against an expected queue,
// register contents against a small reference model kept by the bench.
module tb_sev_seg_capture;

  logic        clk = 1'b0;
  logic        reset;
  logic        a, b, c, d, e, f, g, dot;
  logic [3:0]  an;
  logic [15:0] digits;
  logic [3:0]  dots, valid;
  logic        upd, err;
  logic [3:0]  upd_idx;

  int errors = 0;
  int checks = 0;

  // Entry layout: {err, upd, idx[3:0], value[3:0], valid_bit, dot_bit}
  logic [11:0] exp_q[$];
  logic [15:0] m_digits;
  logic [3:0]  m_valid, m_dots;

  sev_seg_capture #(.DIGITS(4), .STABLE_CYCLES(4)) dut (
    .clk(clk), .reset(reset),
    .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .dot(dot),
    .an(an), .digits(digits), .dots(dots), .valid(valid),
    .upd(upd), .upd_idx(upd_idx), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] pat(input int v);
    case (v)
      0:  pat = 7'b1111110;  1:  pat = 7'b0110000;
      2:  pat = 7'b1101101;  3:  pat = 7'b1111001;
      4:  pat = 7'b0110011;  5:  pat = 7'b1011011;
      6:  pat = 7'b1011111;  7:  pat = 7'b1110000;
      8:  pat = 7'b1111111;  9:  pat = 7'b1111011;
      10: pat = 7'b1110111;  11: pat = 7'b0011111;
      12: pat = 7'b1001110;  13: pat = 7'b0111101;
      14: pat = 7'b1001111;  default: pat = 7'b1000111;
    endcase
  endfunction

  task automatic drive(input logic [3:0] sel, input logic [6:0] seg, input logic dp);
    an = sel;
    {a, b, c, d, e, f, g} = seg;
    dot = dp;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_upd(input int idx, input int val, input logic dp);
    m_digits[idx*4 +: 4] = 4'(val);
    m_valid[idx] = 1'b1;
    m_dots[idx]  = dp;
    exp_q.push_back({1'b0, 1'b1, 4'(idx), 4'(val), 1'b1, dp});
  endtask

  task automatic expect_blank(input int idx, input logic dp);
    m_valid[idx] = 1'b0;
    m_dots[idx]  = dp;
    exp_q.push_back({1'b0, 1'b1, 4'(idx), m_digits[idx*4 +: 4], 1'b0, dp});
  endtask

  task automatic expect_err();
    exp_q.push_back({1'b1, 1'b0, 10'b0});
  endtask

  task automatic check_regs(input string tag);
    check({tag, "_digits"}, digits, m_digits);
    check({tag, "_valid"}, valid, m_valid);
    check({tag, "_dots"}, dots, m_dots);
    check({tag, "_pending"}, exp_q.size(), 0);
  endtask

  // Pulse monitor: every upd/err must match the head of the expected queue.
  always @(negedge clk) begin
    logic [11:0] obs, want;
    if (!reset && (upd || err)) begin
      if (upd)
        obs = {err, 1'b1, upd_idx, 4'(digits >> (upd_idx * 4)),
               1'(valid >> upd_idx), 1'(dots >> upd_idx)};
      else
        obs = {1'b1, 1'b0, 10'b0};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $error("FAIL unexpected_pulse observed=%0h expected=none", obs);
      end else begin
        want = exp_q.pop_front();
        assert (obs === want) else begin
          errors++;
          $error("FAIL pulse observed=%0h expected=%0h", obs, want);
        end
      end
    end
  end

  initial begin
    m_digits = '0; m_valid = '0; m_dots = '0;
    drive(4'b0000, 7'b0, 1'b0);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_digits", digits, 16'h0);
    check("rst_valid", valid, 4'h0);
    check("rst_dots", dots, 4'h0);
    check("rst_upd", upd, 1'b0);
    check("rst_idx", upd_idx, 4'h0);
    check("rst_err", err, 1'b0);
    cyc(8);

    // Latency: vector sampled at E0, pulse visible after edge E0+6.
    drive(4'b0001, pat(1), 1'b0);
    expect_upd(0, 1, 1'b0);
    for (int k = 0; k <= 6; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("latency_e%0d", k), upd, (k == 6));
    end
    cyc(4);
    check_regs("latency");

    // Full hex sweep on digit 2, dot lit only on 9.
    for (int v = 0; v < 16; v++) begin
      drive(4'b0100, pat(v), (v == 9));
      expect_upd(2, v, (v == 9));
      cyc(8);
    end
    check_regs("sweep");

    // Glitches shorter than the stability window, then a single stable value.
    for (int j = 0; j < 8; j++) begin
      drive(4'b0100, pat(j), 1'b0);
      cyc(3);
    end
    drive(4'b0100, pat(3), 1'b0);
    expect_upd(2, 3, 1'b0);
    cyc(28);
    check_regs("glitch");

    // Illegal pattern keeps the digit value but clears valid; blank then clears valid with upd.
    drive(4'b1000, pat(7), 1'b0);
    expect_upd(3, 7, 1'b0);
    cyc(10);
    drive(4'b1000, 7'b1010101, 1'b0);
    expect_err();
    m_valid[3] = 1'b0;
    cyc(10);
    check_regs("illegal");
    drive(4'b1000, 7'b0000000, 1'b0);
    expect_blank(3, 1'b0);
    cyc(10);
    check_regs("blank");

    // Multi-hot select flags once; zero select is silent.
    drive(4'b0011, pat(1), 1'b0);
    expect_err();
    cyc(10);
    check_regs("multihot");
    drive(4'b0000, pat(8), 1'b1);
    cyc(10);
    check_regs("zero_sel");

    // Asynchronous reset mid-cycle while a commit is pending and inputs move.
    drive(4'b0001, pat(5), 1'b0);
    cyc(3);
    #2;
    drive(4'b0010, pat(6), 1'b1);
    #1;
    reset = 1'b1;
    #1;
    check("arst_digits", digits, 16'h0);
    check("arst_valid", valid, 4'h0);
    check("arst_dots", dots, 4'h0);
    check("arst_upd", upd, 1'b0);
    check("arst_idx", upd_idx, 4'h0);
    check("arst_err", err, 1'b0);
    drive(4'b0000, 7'b0, 1'b0);
    m_digits = '0; m_valid = '0; m_dots = '0;
    cyc(2);
    reset = 1'b0;
    cyc(12);
    check_regs("post_reset");

    // Scan loop across all digits, twice.
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 4; i++) begin
        drive(4'(1 << i), pat(i + 1), 1'b0);
        expect_upd(i, i + 1, 1'b0);
        cyc(10);
      end
    end
    check("scan_digits", digits, 16'h4321);
    check("scan_valid", valid, 4'hF);
    check_regs("scan");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
